// File: rtl/aes_key_sch_arb.sv
// aes_key_sch_arb: round-robin arbiter and sequencer for the shared AES-256 key-schedule core,
// with a per-requester cache of the last successfully expanded key.
module aes_key_sch_arb #(
  parameter int START_TIMEOUT = 4,
  parameter int RUN_TIMEOUT   = 32,
  parameter int CNT_W         = 6
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inReq0,
  input  logic [255:0] inKey0,
  output logic         outAck0,
  output logic         outDone0,
  input  logic         inReq1,
  input  logic [255:0] inKey1,
  output logic         outAck1,
  output logic         outDone1,
  input  logic         inFlush,
  output logic         outSchWr,
  output logic [255:0] outSchKey,
  input  logic         inSchBusy,
  output logic         outSchOwner,
  output logic         outSchCapture,
  output logic         outErr,
  output logic         outBusy
);
  typedef enum logic [2:0] {IDLE, HIT, START, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic err_q, err_d, owner_q, owner_d, last_q, last_d;
  logic [255:0] key_q, key_d, sch_key_q, sch_key_d, ck0_q, ck0_d, ck1_q, ck1_d, pkey;
  logic [1:0] vld_q, vld_d, own_bit;
  logic wr_q, wr_d, ack0_q, ack0_d, ack1_q, ack1_d, done0_q, done0_d, done1_q, done1_d;
  logic cap_q, cap_d, oerr_q, oerr_d;
  logic any, pick, hit, sel, fin_or_hit;
  assign any = inReq0 | inReq1;
  // On a tie the requester that was not served last wins.
  assign pick = (inReq0 & inReq1) ? ~last_q : inReq1;
  assign pkey = pick ? inKey1 : inKey0;
  // A flush on the selection edge already counts, so the compare sees invalid entries.
  assign hit = vld_q[pick] & ~inFlush & (pkey == (pick ? ck1_q : ck0_q));
  assign sel = (state_q == IDLE) & any;
  assign cnt_inc = cnt_q + 1'b1;
  assign own_bit = owner_q ? 2'b10 : 2'b01;
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      key_q     <= '0;
      sch_key_q <= '0;
      ck0_q     <= '0;
      ck1_q     <= '0;
      vld_q     <= '0;
      wr_q      <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      cap_q     <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      key_q     <= key_d;
      sch_key_q <= sch_key_d;
      ck0_q     <= ck0_d;
      ck1_q     <= ck1_d;
      vld_q     <= vld_d;
      wr_q      <= wr_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      cap_q     <= cap_d;
      oerr_q    <= oerr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        state_d = any ? (hit ? HIT : START) : IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      HIT: state_d = IDLE;
      START: begin
        state_d = inSchBusy ? RUN : (cnt_inc == CNT_W'(START_TIMEOUT)) ? FIN : START;
        cnt_d   = inSchBusy ? '0 : cnt_inc;
        err_d   = ~inSchBusy & (cnt_inc == CNT_W'(START_TIMEOUT));
      end
      RUN: begin
        state_d = ~inSchBusy ? FIN : (cnt_inc == CNT_W'(RUN_TIMEOUT)) ? FIN : RUN;
        cnt_d   = cnt_inc;
        err_d   = inSchBusy & (cnt_inc == CNT_W'(RUN_TIMEOUT));
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    fin_or_hit = (state_q == HIT) | (state_d == FIN);
    ack0_d     = sel & ~pick;
    ack1_d     = sel & pick;
    wr_d       = sel & ~hit;
    sch_key_d  = wr_d ? pkey : sch_key_q;
    key_d      = sel ? pkey : key_q;
    owner_d    = sel ? pick : owner_q;
    cap_d      = state_d == RUN;
    done0_d    = fin_or_hit & ~owner_q;
    done1_d    = fin_or_hit & owner_q;
    oerr_d     = (state_d == FIN) & err_d;
    last_d     = (state_q == HIT || state_q == FIN) ? owner_q : last_q;
    vld_d      = inFlush ? 2'b00 : (state_q == FIN) ? (err_q ? vld_q & ~own_bit : vld_q | own_bit) : vld_q;
    ck0_d      = (state_q == FIN && !err_q && !owner_q) ? key_q : ck0_q;
    ck1_d      = (state_q == FIN && !err_q && owner_q) ? key_q : ck1_q;
  end
  assign outAck0       = ack0_q;
  assign outAck1       = ack1_q;
  assign outDone0      = done0_q;
  assign outDone1      = done1_q;
  assign outSchWr      = wr_q;
  assign outSchKey     = sch_key_q;
  assign outSchOwner   = owner_q;
  assign outSchCapture = cap_q;
  assign outErr        = oerr_q;
  assign outBusy       = state_q != IDLE;
endmodule

// File: tb/tb_aes_key_sch_arb.sv
// tb_aes_key_sch_arb: randomized and directed checks of aes_key_sch_arb against a
// transaction-level model of arbitration, key caching and core timing.
module tb_aes_key_sch_arb;
  logic inClk = 0, inRstN = 0, inReq0 = 0, inReq1 = 0, inFlush = 0;
  logic [255:0] inKey0 = '0, inKey1 = '0, outSchKey;
  logic outAck0, outDone0, outAck1, outDone1, outSchWr, inSchBusy;
  logic outSchOwner, outSchCapture, outErr, outBusy;
  int n_chk = 0, n_fail = 0;
  int core_d = 1, core_b = 1, core_t = 1000;
  bit core_on = 0;
  bit [1:0] m_valid = '0;
  logic [255:0] m_key [2];
  bit m_last = 1;
  logic [255:0] pool [2][3];
  aes_key_sch_arb dut (
    .inClk(inClk), .inRstN(inRstN),
    .inReq0(inReq0), .inKey0(inKey0), .outAck0(outAck0), .outDone0(outDone0),
    .inReq1(inReq1), .inKey1(inKey1), .outAck1(outAck1), .outDone1(outDone1),
    .inFlush(inFlush), .outSchWr(outSchWr), .outSchKey(outSchKey), .inSchBusy(inSchBusy),
    .outSchOwner(outSchOwner), .outSchCapture(outSchCapture), .outErr(outErr), .outBusy(outBusy)
  );
  always #5 inClk = ~inClk;
  // Core model: busy rises core_d cycles after the write cycle and lasts core_b cycles; core_d=0 never answers.
  always @(posedge inClk) begin
    if (outSchWr) begin
      core_on <= 1;
      core_t  <= 1;
    end else if (core_on) core_t <= core_t + 1;
  end
  assign inSchBusy = core_on && core_d != 0 && core_t >= core_d && core_t < core_d + core_b;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rkey();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic logic [8:0] outs();
    return {outAck0, outDone0, outAck1, outDone1, outSchWr, outSchOwner, outSchCapture, outErr, outBusy};
  endfunction
  // fm: 0 no flush, 1 flush on the selection edge, 2 flush during the first done pulse.
  task automatic run(input bit r0, input bit r1, input logic [255:0] k0, input logic [255:0] k1,
                     input int d, input int b, input int fm);
    int ord [2];
    int n, s, x, e_done, e_cap, e_wr, n_wr, n_cap, n_dn;
    int e_ack [2], e_dn [2], g_ack [2], g_dn [2], c_ack [2], c_dn [2];
    bit e_err [2], e_miss [2], g_err [2], w_ack [2], o_ack [2];
    logic [255:0] kk [2], sk_ack [2];
    bit hit;
    kk[0] = k0; kk[1] = k1;
    n = int'(r0) + int'(r1);
    ord[0] = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
    ord[1] = 1 - ord[0];
    core_d = d; core_b = b;
    s = 1; e_cap = 0; e_wr = 0;
    for (int i = 0; i < n; i++) begin
      x = ord[i];
      if (i == 0 && fm == 1) m_valid = '0;
      hit = m_valid[x] && m_key[x] == kk[x];
      e_ack[x] = s;
      e_miss[x] = !hit;
      e_done = hit ? s + 1 : (d == 0 ? s + 4 : s + d + b + 1);
      e_dn[x] = e_done;
      e_err[x] = !hit && d == 0;
      if (!hit) begin
        e_wr++;
        if (d != 0) e_cap += b;
        m_valid[x] = d != 0;
        m_key[x] = kk[x];
      end
      m_last = x[0];
      if (i == 0 && fm == 2) m_valid = '0;
      s = e_done + (hit ? 1 : 2);
    end
    for (int i = 0; i < 2; i++) begin
      g_ack[i] = -1; g_dn[i] = -1; c_ack[i] = 0; c_dn[i] = 0; g_err[i] = 0; w_ack[i] = 0; o_ack[i] = 0; sk_ack[i] = '0;
    end
    n_wr = 0; n_cap = 0; n_dn = 0;
    inReq0 = r0; inKey0 = k0; inReq1 = r1; inKey1 = k1; inFlush = fm == 1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge inClk);
      inFlush = 0;
      if (outAck0) begin c_ack[0]++; g_ack[0] = c; w_ack[0] = outSchWr; o_ack[0] = outSchOwner; sk_ack[0] = outSchKey; inReq0 = 0; end
      if (outAck1) begin c_ack[1]++; g_ack[1] = c; w_ack[1] = outSchWr; o_ack[1] = outSchOwner; sk_ack[1] = outSchKey; inReq1 = 0; end
      if (outDone0) begin c_dn[0]++; g_dn[0] = c; g_err[0] = outErr; end
      if (outDone1) begin c_dn[1]++; g_dn[1] = c; g_err[1] = outErr; end
      if ((outDone0 || outDone1) && n_dn++ == 0 && fm == 2) inFlush = 1;
      if (outSchWr) n_wr++;
      if (outSchCapture) n_cap++;
    end
    for (int i = 0; i < n; i++) begin
      x = ord[i];
      check($sformatf("ack_cycle%0d", x), g_ack[x], e_ack[x]);
      check($sformatf("ack_count%0d", x), c_ack[x], 1);
      check($sformatf("done_cycle%0d", x), g_dn[x], e_dn[x]);
      check($sformatf("done_count%0d", x), c_dn[x], 1);
      check($sformatf("err%0d", x), g_err[x], e_err[x]);
      check($sformatf("wr_at_ack%0d", x), w_ack[x], e_miss[x]);
      check($sformatf("owner%0d", x), o_ack[x], x);
      if (e_miss[x]) check($sformatf("sch_key%0d", x), sk_ack[x], kk[x]);
    end
    check("wr_total", n_wr, e_wr);
    check("capture_cycles", n_cap, e_cap);
    check("idle_after", outBusy, 0);
  endtask
  task automatic pulse_flush();
    inFlush = 1;
    @(negedge inClk);
    inFlush = 0;
    m_valid = '0;
  endtask
  initial begin
    logic [255:0] k_inc, ka, kb, kt, kf, kr;
    for (int i = 0; i < 32; i++) k_inc[255 - 8 * i -: 8] = 8'(i);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) pool[i][j] = rkey();
    m_key[0] = '0; m_key[1] = '0;
    ka = rkey(); kb = rkey(); kt = rkey(); kf = rkey(); kr = rkey();
    #1 check("reset_outs", outs(), 9'd0);
    check("reset_key", outSchKey, '0);
    repeat (3) @(negedge inClk);
    inRstN = 1;
    @(negedge inClk);
    run(1, 1, ka, kb, 1, 4, 0);
    run(1, 1, kb, ka, 2, 3, 0);
    run(1, 0, k_inc, '0, 1, 8, 0);
    run(1, 0, k_inc, '0, 1, 8, 0);
    run(1, 0, ka ^ k_inc, '0, 1, 5, 0);
    run(0, 1, '0, kf, 1, 4, 0);
    pulse_flush();
    run(0, 1, '0, kf, 1, 4, 0);
    run(1, 0, kt, '0, 0, 1, 0);
    run(1, 0, kt, '0, 1, 3, 0);
    run(1, 0, kt, '0, 1, 3, 1);
    run(1, 0, kt, '0, 2, 2, 2);
    run(1, 0, kt, '0, 1, 1, 0);
    run(1, 0, kr, '0, 1, 3, 0);
    core_d = 1; core_b = 8;
    inReq0 = 1; inKey0 = kf;
    @(negedge inClk);
    check("rst_test_ack", outAck0, 1);
    inReq0 = 0;
    repeat (3) @(negedge inClk);
    check("rst_test_capture", outSchCapture, 1);
    inRstN = 0;
    #1 check("rst_mid_outs", outs(), 9'd0);
    check("rst_mid_key", outSchKey, '0);
    m_valid = '0; m_last = 1;
    repeat (4) @(negedge inClk);
    inRstN = 1;
    begin
      int dn = 0;
      repeat (12) begin
        @(negedge inClk);
        dn += int'(outDone0) + int'(outDone1);
      end
      check("rst_no_done", dn, 0);
    end
    run(1, 0, kr, '0, 1, 3, 0);
    for (int it = 0; it < 30; it++) begin
      int r, v, d;
      r = $urandom_range(1, 3);
      v = $urandom_range(0, 5);
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      run(r[0], r[1], pool[0][$urandom_range(0, 2)], pool[1][$urandom_range(0, 2)],
          d, $urandom_range(1, 12), v == 4 ? 1 : (v == 5 ? 2 : 0));
      if ($urandom_range(0, 9) == 0) pulse_flush();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
